// File: rtl/ex_result_demux.sv
// Purpose : routes execute-stage result words to one of two 2-entry FIFO output channels (A/B).
// Latency : 1 cycle from input handshake to X_valid; no combinational in-to-out data path.
// Backpres: in_ready drops when the queue picked by in_sel is full; a same-cycle pop does not free it.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_data/in_sel/in_valid     - result word, route (0 = A, 1 = B), qualifier
//   in_ready                    - word accepted this cycle (combinational)
//   a_data/a_valid/a_ready      - channel A stream
//   b_data/b_valid/b_ready      - channel B stream
//   a_count/b_count             - 16-bit delivered-word counters, present only with EX_DEMUX_CNT_EN
//
// Optional feature macro: EX_DEMUX_CNT_EN (delivered-word counters).

module ex_result_demux #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready
`ifdef EX_DEMUX_CNT_EN
  ,
  output logic [15:0]       a_count,
  output logic [15:0]       b_count
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // The storage below is a fixed head/tail pair; other depths are not built.
  if (DEPTH != 2) begin : g_depth_chk
    $error("ex_result_demux supports DEPTH == 2 only");
  end

  // Index 0 is channel A, index 1 is channel B.
  logic [DATA_W-1:0] head [2];
  logic [DATA_W-1:0] tail [2];
  logic [OCC_W-1:0]  occ  [2];
  logic [1:0]        vld;
  logic [1:0]        has_room;
  logic [1:0]        push;
  logic [1:0]        pop;

  assign vld[0]      = (occ[0] != '0);
  assign vld[1]      = (occ[1] != '0);
  assign has_room[0] = (occ[0] < OCC_W'(DEPTH));
  assign has_room[1] = (occ[1] < OCC_W'(DEPTH));

  // Readiness looks only at the registered occupancy, so a full queue
  // never accepts a word even when it is being drained in the same cycle.
  assign in_ready = !rst && has_room[in_sel];

  assign push[0] = in_valid && in_ready && !in_sel;
  assign push[1] = in_valid && in_ready &&  in_sel;
  assign pop[0]  = vld[0] && a_ready;
  assign pop[1]  = vld[1] && b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        occ[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        unique case ({push[c], pop[c]})
          2'b10: begin
            if (occ[c] == '0) head[c] <= in_data;
            else              tail[c] <= in_data;
            occ[c] <= occ[c] + 1'b1;
          end
          2'b01: begin
            // Draining the last entry leaves head untouched so the data
            // output keeps showing the word that just left.
            if (occ[c] == OCC_W'(2)) head[c] <= tail[c];
            occ[c] <= occ[c] - 1'b1;
          end
          2'b11: begin
            // Only reachable at occupancy 1: the new word replaces the
            // departing head directly.
            head[c] <= in_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign a_data  = head[0];
  assign b_data  = head[1];
  assign a_valid = vld[0];
  assign b_valid = vld[1];

`ifdef EX_DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      // Free-running 16-bit counters, wrapping naturally at 65535.
      a_count <= a_count + 16'(pop[0]);
      b_count <= b_count + 16'(pop[1]);
    end
  end
`endif

endmodule

// File: tb/tb_ex_result_demux.sv
module tb_ex_result_demux;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
`ifdef EX_DEMUX_CNT_EN
  logic [15:0]  a_count;
  logic [15:0]  b_count;
`endif

  always #5 clk = ~clk;

  ex_result_demux #(.DATA_W(W), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
`ifdef EX_DEMUX_CNT_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two plain FIFOs plus the last word each channel showed.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;
  int           cnt_a  = 0;
  int           cnt_b  = 0;

  // Expectations of the current cycle, computed before the edge.
  logic e_rdy, e_av, e_bv;

  typedef struct {
    logic         r, v, s;
    logic [W-1:0] d;
    logic         ar, br;
    logic         x_rdy, x_av;
    logic [W-1:0] x_ad;
    logic         x_bv;
    logic [W-1:0] x_bd;
  } tv_t;

  tv_t tq[$];

  task automatic row(input logic r, v, s, input logic [W-1:0] d, input logic ar, br,
                     input logic x_rdy, x_av, input logic [W-1:0] x_ad,
                     input logic x_bv, input logic [W-1:0] x_bd);
    tv_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.ar = ar; t.br = br;
    t.x_rdy = x_rdy; t.x_av = x_av; t.x_ad = x_ad; t.x_bv = x_bv; t.x_bd = x_bd;
    tq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive inputs, then at the falling edge compare outputs with the model.
  task automatic drive_check(input logic r, v, s, input logic [W-1:0] d, input logic ar, br);
    rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    @(negedge clk);
    e_av  = (qa.size() > 0);
    e_bv  = (qb.size() > 0);
    e_rdy = !r && ((s ? qb.size() : qa.size()) < 2);
    chk("model in_ready", 64'(in_ready), 64'(e_rdy));
    chk("model a_valid",  64'(a_valid),  64'(e_av));
    chk("model b_valid",  64'(b_valid),  64'(e_bv));
    chk("model a_data",   64'(a_data),   64'(e_av ? qa[0] : last_a));
    chk("model b_data",   64'(b_data),   64'(e_bv ? qb[0] : last_b));
`ifdef EX_DEMUX_CNT_EN
    chk("model a_count",  64'(a_count),  64'(cnt_a & 16'hFFFF));
    chk("model b_count",  64'(b_count),  64'(cnt_b & 16'hFFFF));
`endif
  endtask

  // Advance across the rising edge and update the model with the handshakes.
  task automatic commit();
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
      cnt_a = 0; cnt_b = 0;
    end else begin
      if (e_av && a_ready) begin last_a = qa.pop_front(); cnt_a++; end
      if (e_bv && b_ready) begin last_b = qb.pop_front(); cnt_b++; end
      if (in_valid && e_rdy) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic step(input logic r, v, s, input logic [W-1:0] d, input logic ar, br);
    drive_check(r, v, s, d, ar, br);
    commit();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //   r  v  s  data       ar br | rdy av a_data     bv b_data
    row(1, 0, 0, 32'h0,     0, 0,   0, 0, 32'h0,     0, 32'h0);  // reset state
    row(0, 1, 0, 32'h11,    1, 0,   1, 0, 32'h0,     0, 32'h0);  // push 0x11 to A
    row(0, 0, 0, 32'h0,     1, 0,   1, 1, 32'h11,    0, 32'h0);  // A visible next cycle
    row(0, 1, 1, 32'hA,     1, 0,   1, 0, 32'h11,    0, 32'h0);  // push A-word to B
    row(0, 1, 1, 32'hB,     0, 0,   1, 0, 32'h11,    1, 32'hA);
    row(0, 1, 1, 32'hC,     0, 0,   0, 0, 32'h11,    1, 32'hA);  // B full: stall
    row(0, 1, 1, 32'hC,     0, 1,   0, 0, 32'h11,    1, 32'hA);  // pop does not free slot
    row(0, 1, 1, 32'hC,     0, 1,   1, 0, 32'h11,    1, 32'hB);  // 0xC accepted with pop
    row(0, 0, 1, 32'h0,     0, 1,   1, 0, 32'h11,    1, 32'hC);
    row(0, 0, 0, 32'h0,     0, 0,   1, 0, 32'h11,    0, 32'hC);  // B empty, data held
    row(0, 1, 0, 32'h1,     0, 0,   1, 0, 32'h11,    0, 32'hC);  // A head 0x1
    row(0, 1, 0, 32'h2,     1, 0,   1, 1, 32'h1,     0, 32'hC);  // push+pop at occ 1
    row(0, 0, 0, 32'h0,     0, 0,   1, 1, 32'h2,     0, 32'hC);  // new head, occ still 1
    row(0, 1, 0, 32'h3,     0, 0,   1, 1, 32'h2,     0, 32'hC);  // fill A
    row(0, 1, 0, 32'h4,     0, 0,   0, 1, 32'h2,     0, 32'hC);  // A full: stall
    row(0, 1, 1, 32'h5,     0, 0,   1, 1, 32'h2,     0, 32'hC);  // B still accepts
    row(0, 0, 1, 32'h0,     0, 0,   1, 1, 32'h2,     1, 32'h5);
    row(1, 0, 0, 32'h0,     0, 0,   0, 1, 32'h2,     1, 32'h5);  // one-cycle reset
    row(0, 0, 0, 32'h0,     0, 0,   1, 0, 32'h0,     0, 32'h0);  // queues flushed

    foreach (tq[i]) begin
      drive_check(tq[i].r, tq[i].v, tq[i].s, tq[i].d, tq[i].ar, tq[i].br);
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tq[i].x_rdy));
      chk($sformatf("vec%0d a_valid", i),  64'(a_valid),  64'(tq[i].x_av));
      chk($sformatf("vec%0d a_data", i),   64'(a_data),   64'(tq[i].x_ad));
      chk($sformatf("vec%0d b_valid", i),  64'(b_valid),  64'(tq[i].x_bv));
      chk($sformatf("vec%0d b_data", i),   64'(b_data),   64'(tq[i].x_bd));
      commit();
    end

    // Randomized traffic, including occasional resets and idle sel toggling.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           $urandom,
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0));
    end

`ifdef EX_DEMUX_CNT_EN
    // Counter wrap: 65537 pops on A leave a_count at 1.
    step(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 65538; i++) begin
      step(0, 1, 0, W'(i), 1, 0);
    end
    drive_check(0, 0, 0, '0, 0, 0);
    chk("wrap a_count", 64'(a_count), 64'd1);
    chk("wrap b_count", 64'(b_count), 64'd0);
    commit();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the test sequence ever stops advancing.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
